// File: rtl/spi_mstr_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared types, constants and helpers for the spi_mstr_gen SPI
//            master (mode 3) and its SCLK generator.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BITS  = 2'd1,
    TRAIL = 2'd2
  } spi_state_t;

  // clk cycles after an SCLK rise at which MISO is sampled and the shift
  // register advances (lands inside the SCLK-high half)
  localparam int SAMPLE_DLY = 2;

  // Reverse the low w bits of v; result is right-aligned, upper bits zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = {<<{v}};
    return r >> (32 - w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_sclk_gen
// Purpose  : Clock divider for the SPI master. Holds the free-running
//            divider, a registered glitch-free SCLK (idles high), the
//            "first rise seen" flag and the MISO sample strobe.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_LOG2 = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,      // hold divider and rise flag at zero
  input  logic                run,      // SCLK toggles only while high
  output logic [DIV_LOG2-1:0] div_cnt,
  output logic                sclk,
  output logic                sample
);

  logic [DIV_LOG2-1:0] div_nxt;
  logic                rise_seen;

  assign div_nxt = div_cnt + DIV_LOG2'(1);

  // Divider counter: cleared when idle or finishing, otherwise wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   div_cnt <= '0;
    else if (clr) div_cnt <= '0;
    else          div_cnt <= div_nxt;
  end

  // SCLK flop tracks ~div_cnt[MSB] one cycle ahead so the pin is a pure flop output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sclk <= 1'b1;
    else if (run) sclk <= ~div_nxt[DIV_LOG2-1];
    else          sclk <= 1'b1;
  end

  // Remember that at least one rising edge has been issued in this transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  rise_seen <= 1'b0;
    else if (clr)                rise_seen <= 1'b0;
    else if (run && (&div_cnt))  rise_seen <= 1'b1;
  end

  assign sample = run && rise_seen && (div_cnt == DIV_LOG2'(SAMPLE_DLY));

endmodule
`default_nettype wire

// File: rtl/spi_mstr_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_mstr_gen
// Purpose  : Parametrised SPI master, mode 3 (CPOL=1, CPHA=1). Shifts a
//            DATA_W-bit command out on MOSI while capturing DATA_W bits
//            from MISO, with selectable slave, bit order, busy/done status
//            and a held read-data register.
// Revision : 1.0 - initial release
// ============================================================================
module spi_mstr_gen
  import spi_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int DIV_LOG2  = 5,
  parameter  int NUM_SS    = 1,
  parameter  int MSB_FIRST = 1,
  localparam int SEL_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [DATA_W-1:0] cmd,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic [NUM_SS-1:0] SS_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int H     = 1 << (DIV_LOG2 - 1);

  // Reject unsupported configurations at elaboration
  if (DATA_W < 2 || DATA_W > 32 || DIV_LOG2 < 3 || DIV_LOG2 > 8 ||
      NUM_SS < 1 || NUM_SS > 8 || (MSB_FIRST != 0 && MSB_FIRST != 1)) begin : g_param_chk
    $error("spi_mstr_gen: parameter out of supported range");
  end

  spi_state_t          state;
  spi_state_t          state_nxt;
  logic                accept;
  logic                xfer_end;
  logic                sel_ok;
  logic                sample;
  logic [DIV_LOG2-1:0] div_cnt;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   cmd_rev;
  logic [DATA_W-1:0]   shift_rev;
  logic [CNT_W-1:0]    bit_cnt;

  assign sel_ok    = 32'(ss_sel) < 32'(NUM_SS);
  assign cmd_rev   = DATA_W'(bit_rev(32'(cmd), DATA_W));
  assign shift_rev = DATA_W'(bit_rev(32'(shift_q), DATA_W));
  assign MOSI      = shift_q[DATA_W-1];

  spi_sclk_gen #(
    .DIV_LOG2 (DIV_LOG2)
  ) u_sclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((state == IDLE) || xfer_end),
    .run     (state == BITS),
    .div_cnt (div_cnt),
    .sclk    (SCLK),
    .sample  (sample)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode plus accept / end-of-transfer strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    xfer_end  = 1'b0;
    case (state)
      IDLE: begin
        if (wrt && sel_ok) begin
          accept    = 1'b1;
          state_nxt = BITS;
        end
      end
      BITS: begin
        if (sample && (bit_cnt == CNT_W'(DATA_W - 1))) state_nxt = TRAIL;
      end
      TRAIL: begin
        if (div_cnt == DIV_LOG2'(H - 1)) begin
          xfer_end  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and bit counter: load on accept, shift on each sample strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shift_q <= (MSB_FIRST != 0) ? cmd : cmd_rev;
      bit_cnt <= '0;
    end else if (sample) begin
      shift_q <= {shift_q[DATA_W-2:0], MISO};
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Status flags and the held receive word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_data <= '0;
    end else if (accept) begin
      busy <= 1'b1;
      done <= 1'b0;
    end else if (xfer_end) begin
      busy    <= 1'b0;
      done    <= 1'b1;
      rd_data <= (MSB_FIRST != 0) ? shift_q : shift_rev;
    end
  end

  // One set/reset flop per slave select so each pin is glitch-free
  for (genvar i = 0; i < NUM_SS; i++) begin : g_ss
    logic ss_q;
    // Drop the selected line on accept, release all lines at the end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      ss_q <= 1'b1;
      else if (accept && (ss_sel == SEL_W'(i)))        ss_q <= 1'b0;
      else if (xfer_end)                               ss_q <= 1'b1;
    end
    assign SS_n[i] = ss_q;
  end

endmodule
`default_nettype wire
